serial_adder_ctrl: RTL

//  Sequencer that time-shares one 1-bit full-adder cell to add two WIDTH-bit operands bit-serially, LSB first.

---
 rtl/serial_adder_defs.sv | 17 +
 rtl/full_adder.sv | 28 ++
 rtl/serial_adder_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/serial_adder_defs.sv
// -----------------------------------------------------------------------------
// serial_adder_defs
// Shared definitions for the bit-serial adder sequencer.
//   state_t       : controller state encoding (ST_IDLE, ST_RUN, ST_DONE)
//   DEFAULT_WIDTH : default operand/sum width
// -----------------------------------------------------------------------------
package serial_adder_defs;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// 1-bit full-adder cell built from a 3-to-8 minterm decoder: the input triple
// selects one minterm line, and sum/carry are the OR of their true minterms.
// Ports:
//   a, b, ci : addend bits and carry-in
//   s        : sum bit
//   co       : carry-out
// -----------------------------------------------------------------------------
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic [2:0] sel;
   logic [7:0] minterm;

   assign sel     = {a, b, ci};
   assign minterm = 8'b0000_0001 << sel;

   // sum true for odd parity (1,2,4,7); carry true for two or more ones (3,5,6,7)
   assign s  = minterm[1] | minterm[2] | minterm[4] | minterm[7];
   assign co = minterm[3] | minterm[5] | minterm[6] | minterm[7];

endmodule

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
// Adds two WIDTH-bit operands bit-serially (LSB first) through one shared
// full_adder cell with a registered carry. Operands are captured on an accepted
// start; WIDTH add cycles follow; then sum/cout are presented with a one-cycle
// done pulse.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   defined   : adds port 'sub'; sub=1 captured on start computes a-b
//               (B loads ~b, carry loads 1, cin ignored); cout=1 means no borrow.
//   undefined : add-only, no 'sub' port.
//
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : request, sampled only in IDLE
//   a, b, cin  : operands and initial carry, captured on accepted start
//   sub        : (SERIAL_ADDER_SUB_EN only) subtract select, captured on start
//   busy       : high while in RUN
//   done       : one-cycle result-valid pulse
//   sum, cout  : result, held from done until the next result is produced
//
// Handshake: start acts as a request whose implicit ready is "state is IDLE";
// a start seen in RUN or DONE is dropped, not queued. done is a single-cycle
// valid with no backpressure; sum/cout stay stable after it until the next
// operation completes (or reset).
// -----------------------------------------------------------------------------
module serial_adder_ctrl
   import serial_adder_defs::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_sr_q, a_sr_d;
   logic [WIDTH-1:0]   b_sr_q, b_sr_d;
   // Only WIDTH-1 accumulated bits are kept; the final bit joins them
   // directly on the way into the result register.
   logic [WIDTH-2:0]   sum_sr_q, sum_sr_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;

   logic               cell_s;
   logic               cell_co;
   logic [WIDTH-1:0]   sum_shift;
   logic [WIDTH-1:0]   b_load;
   logic               carry_load;

   full_adder u_cell (
      .a  (a_sr_q[0]),
      .b  (b_sr_q[0]),
      .ci (carry_q),
      .s  (cell_s),
      .co (cell_co)
   );

   // New bit enters at the MSB; after WIDTH steps bit 0 sits at the LSB.
   assign sum_shift = {cell_s, sum_sr_q};

   always_comb begin
      b_load     = b;
      carry_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
      if (sub) begin
         b_load     = ~b;
         carry_load = 1'b1;
      end
`endif
   end

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      sum_sr_d = sum_sr_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      cout_d   = cout_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_sr_d   = a;
               b_sr_d   = b_load;
               carry_d  = carry_load;
               cnt_d    = '0;
               sum_sr_d = '0;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            sum_sr_d = sum_shift[WIDTH-1:1];
            carry_d  = cell_co;
            if (cnt_q == CNT_LAST) begin
               // MSB step: publish the result; counter holds rather than wrap.
               sum_d   = sum_shift;
               cout_d  = cell_co;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_sr_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         sum_sr_q <= sum_sr_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule
